persistencia_alarma_mc: RTL

- Multi-channel temperature-alarm qualifier with persistence, hysteresis and sticky alarm latches.
- Each channel runs its own FSM. Raw low/high threshold crossings must persist for N_ON consecutive valid samples before an alarm is declared. The alarm clears only after N_OFF consecutive samples back inside the hysteresis band.
- Sits between the sampled-temperature path and the interrupt/actuator controller; one instance covers all sensor channels.

---
 rtl/persistencia_pkg.sv | 21 ++
 rtl/persistencia_canal.sv | 135 +++++++++++++
 rtl/persistencia_alarma_mc.sv | 70 +++++++
 3 files changed

// File: rtl/persistencia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : persistencia_pkg
// Description : Shared state type and default constants for the
//               temperature-alarm persistence qualifier.
// Revision    : 1.0 - initial release
// ============================================================================
package persistencia_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FRIO   = 2'd1,
        CALOR  = 2'd2
    } estado_t;

    localparam int N_ON_DEF   = 5;
    localparam int N_OFF_DEF  = 3;
    localparam int TEMP_W_DEF = 9;

endpackage
`default_nettype wire

// File: rtl/persistencia_canal.sv
`default_nettype none
// ============================================================================
// Module      : persistencia_canal
// Description : Single-channel alarm FSM with persistence counters,
//               hysteresis exit and sticky alarm latches.
// Revision    : 1.0 - initial release
// ============================================================================
module persistencia_canal
    import persistencia_pkg::*;
#(
    parameter int TEMP_W = TEMP_W_DEF,
    parameter int N_ON   = N_ON_DEF,
    parameter int N_OFF  = N_OFF_DEF,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] umbral_bajo,
    input  logic [TEMP_W-1:0] umbral_alto,
    input  logic [TEMP_W-1:0] histeresis,
    input  logic              ack,
    output logic              alarma_baja,
    output logic              alarma_alta,
    output logic              latch_baja,
    output logic              latch_alta
);

    localparam logic [CNT_W-1:0] c_on  = CNT_W'(N_ON);
    localparam logic [CNT_W-1:0] c_off = CNT_W'(N_OFF);

    estado_t          r_estado;
    estado_t          w_estado_nx;
    logic [CNT_W-1:0] r_cnt_b;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] w_cnt_b_nx;
    logic [CNT_W-1:0] w_cnt_a_nx;
    logic             r_latch_b;
    logic             r_latch_a;
    logic             w_set_b;
    logic             w_set_a;

    // Exit comparisons use one extra bit so threshold+margin never wraps.
    logic [TEMP_W:0]  w_lim_bajo;
    logic [TEMP_W:0]  w_temp_h;
    logic             w_es_bajo;
    logic             w_es_alto;
    logic             w_sal_bajo;
    logic             w_sal_alto;

    assign w_lim_bajo = {1'b0, umbral_bajo} + {1'b0, histeresis};
    assign w_temp_h   = {1'b0, temp} + {1'b0, histeresis};
    assign w_es_bajo  = (temp < umbral_bajo);
    assign w_es_alto  = (temp > umbral_alto);
    assign w_sal_bajo = ({1'b0, temp} >= w_lim_bajo);
    assign w_sal_alto = (w_temp_h <= {1'b0, umbral_alto});

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_estado  <= NORMAL;
            r_cnt_b   <= '0;
            r_cnt_a   <= '0;
            r_latch_b <= 1'b0;
            r_latch_a <= 1'b0;
        end else begin
            r_estado  <= w_estado_nx;
            r_cnt_b   <= w_cnt_b_nx;
            r_cnt_a   <= w_cnt_a_nx;
            r_latch_b <= w_set_b | (r_latch_b & ~ack);
            r_latch_a <= w_set_a | (r_latch_a & ~ack);
        end
    end

    always_comb begin
        w_estado_nx = r_estado;
        w_cnt_b_nx  = r_cnt_b;
        w_cnt_a_nx  = r_cnt_a;
        w_set_b     = 1'b0;
        w_set_a     = 1'b0;
        if (sample_valid) begin
            case (r_estado)
                NORMAL: begin
                    w_cnt_b_nx = w_es_bajo ? sat_inc(r_cnt_b, c_on) : '0;
                    w_cnt_a_nx = w_es_alto ? sat_inc(r_cnt_a, c_on) : '0;
                    // Cold is checked first so misprogrammed thresholds favour FRIO.
                    if (w_es_bajo && (w_cnt_b_nx == c_on)) begin
                        w_estado_nx = FRIO;
                        w_cnt_b_nx  = '0;
                        w_cnt_a_nx  = '0;
                        w_set_b     = 1'b1;
                    end else if (w_es_alto && (w_cnt_a_nx == c_on)) begin
                        w_estado_nx = CALOR;
                        w_cnt_b_nx  = '0;
                        w_cnt_a_nx  = '0;
                        w_set_a     = 1'b1;
                    end
                end
                FRIO: begin
                    w_cnt_b_nx = w_sal_bajo ? sat_inc(r_cnt_b, c_off) : '0;
                    if (w_cnt_b_nx == c_off) begin
                        w_estado_nx = NORMAL;
                        w_cnt_b_nx  = '0;
                        w_cnt_a_nx  = '0;
                    end
                end
                CALOR: begin
                    w_cnt_a_nx = w_sal_alto ? sat_inc(r_cnt_a, c_off) : '0;
                    if (w_cnt_a_nx == c_off) begin
                        w_estado_nx = NORMAL;
                        w_cnt_b_nx  = '0;
                        w_cnt_a_nx  = '0;
                    end
                end
                default: begin
                    w_estado_nx = NORMAL;
                    w_cnt_b_nx  = '0;
                    w_cnt_a_nx  = '0;
                end
            endcase
        end
    end

    assign alarma_baja = (r_estado == FRIO);
    assign alarma_alta = (r_estado == CALOR);
    assign latch_baja  = r_latch_b;
    assign latch_alta  = r_latch_a;

endmodule
`default_nettype wire

// File: rtl/persistencia_alarma_mc.sv
`default_nettype none
// ============================================================================
// Module      : persistencia_alarma_mc
// Description : Multi-channel temperature-alarm qualifier; one FSM per
//               channel plus a registered interrupt summarising all latches.
// Revision    : 1.0 - initial release
// ============================================================================
module persistencia_alarma_mc
    import persistencia_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int TEMP_W = TEMP_W_DEF,
    parameter int N_ON   = N_ON_DEF,
    parameter int N_OFF  = N_OFF_DEF,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [NCH-1:0]        sample_valid,
    input  logic [NCH*TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0]     umbral_bajo,
    input  logic [TEMP_W-1:0]     umbral_alto,
    input  logic [TEMP_W-1:0]     histeresis,
    input  logic [NCH-1:0]        ack,
    output logic [NCH-1:0]        alarma_baja,
    output logic [NCH-1:0]        alarma_alta,
    output logic [NCH-1:0]        latch_baja,
    output logic [NCH-1:0]        latch_alta,
    output logic                  irq
);

    logic r_irq;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_canal
            persistencia_canal #(
                .TEMP_W (TEMP_W),
                .N_ON   (N_ON),
                .N_OFF  (N_OFF),
                .CNT_W  (CNT_W)
            ) u_canal (
                .clk          (clk),
                .arst_n       (arst_n),
                .sample_valid (sample_valid[i]),
                .temp         (temp[i*TEMP_W +: TEMP_W]),
                .umbral_bajo  (umbral_bajo),
                .umbral_alto  (umbral_alto),
                .histeresis   (histeresis),
                .ack          (ack[i]),
                .alarma_baja  (alarma_baja[i]),
                .alarma_alta  (alarma_alta[i]),
                .latch_baja   (latch_baja[i]),
                .latch_alta   (latch_alta[i])
            );
        end
    endgenerate

    // Registered so the interrupt line is glitch-free, one cycle behind the latches.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |{latch_baja, latch_alta};
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire
